// File: rtl/io_periph_sequencer.sv
// Shares one begin/busy I/O peripheral between two requesters with round-robin arbitration and a write FIFO.
// Optional ack watchdog: define IO_SEQ_WATCHDOG_EN.
module io_periph_sequencer #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req0_valid,
    input  logic [DATA_W-1:0]             req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [DATA_W-1:0]             req1_data,
    output logic                          req1_ready,
    output logic [DATA_W-1:0]             periph_data,
    output logic                          periph_begin,
    input  logic [31:0]                   periph_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          seq_busy,
    output logic                          done_pulse,
    output logic                          err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    // Handshake: a word transfers on a rising edge where valid and ready are both high;
    // ready depends only on registered count, the RR pointer and both valids.
    state_t              state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic                rr_ptr;
    logic                full;
    logic                empty;
    logic                contested;
    logic                push;
    logic                pop;
    logic                busy_in;
    logic [DATA_W-1:0]   push_data;
    logic                state_unused;

    assign busy_in      = periph_state[0];
    assign state_unused = ^periph_state[31:1];

    assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign empty      = (fifo_count == '0);
    assign req0_ready = !full && req0_valid && (!req1_valid || !rr_ptr);
    assign req1_ready = !full && req1_valid && (!req0_valid || rr_ptr);
    assign contested  = !full && req0_valid && req1_valid;
    assign push       = req0_ready || req1_ready;
    assign push_data  = req0_ready ? req0_data : req1_data;
    // Never start while the peripheral reports busy; it has no reset of its own.
    assign pop        = (state == IDLE) && !empty && !busy_in;
    assign seq_busy   = !empty || (state != IDLE);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            rr_ptr     <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (contested) begin
                rr_ptr <= ~rr_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef IO_SEQ_WATCHDOG_EN
    localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt;
`else
    logic wd_limit_unused;
    assign wd_limit_unused = (ACK_TIMEOUT > 0);
    assign err             = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            periph_data  <= '0;
            periph_begin <= 1'b0;
            done_pulse   <= 1'b0;
`ifdef IO_SEQ_WATCHDOG_EN
            wd_cnt       <= '0;
            err          <= 1'b0;
`endif
        end else begin
            periph_begin <= 1'b0;
            done_pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        periph_data  <= mem[head];
                        periph_begin <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
`ifdef IO_SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (busy_in) begin
                        state <= WAIT_DONE;
`ifdef IO_SEQ_WATCHDOG_EN
                    end else if (wd_cnt == WD_W'(ACK_TIMEOUT - 1)) begin
                        // Peripheral never acknowledged: drop the word and flag it.
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!busy_in) begin
                        state      <= IDLE;
                        done_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_periph_sequencer.sv
// Directed bench for io_periph_sequencer: transaction-level model plus a begin/busy peripheral model.
module tb_io_periph_sequencer;
    localparam int DATA_W      = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    logic              clock;
    logic              reset_n;
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic [DATA_W-1:0] periph_data;
    logic              periph_begin;
    logic [31:0]       periph_state;
    logic [CNT_W-1:0]  fifo_count;
    logic              seq_busy;
    logic              done_pulse;
    logic              err;

    io_periph_sequencer #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .periph_data(periph_data), .periph_begin(periph_begin), .periph_state(periph_state),
        .fifo_count(fifo_count), .seq_busy(seq_busy), .done_pulse(done_pulse), .err(err)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // scoreboard and model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] issue_log[$];
    int                grant_log[$];
    bit                m_rr, m_inflight, m_acked, m_err;
    int                m_age;
    logic [DATA_W-1:0] m_last_data;
    bit                last_acc0, last_acc1;
    bit                p_stall, p_noack, p_busy;
    int                p_len, p_cnt;
    int                checks, failures, begin_count, done_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Peripheral: goes busy on the begin strobe for p_len cycles; never resets.
    task automatic periph_update();
        if (periph_begin && !p_noack) p_cnt = p_len;
        p_busy = p_stall || (p_cnt != 0);
        if (p_cnt != 0) p_cnt--;
        periph_state = {31'b0, p_busy};
    endtask

    task automatic cycle(input bit v0, input logic [DATA_W-1:0] d0,
                         input bit v1, input logic [DATA_W-1:0] d1);
        bit full, p0, p1, busy_e, exp_begin, exp_done;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        #1;
        full = (exp_q.size() == FIFO_DEPTH);
        p0 = !full && v0 && (!v1 || !m_rr);
        p1 = !full && v1 && (!v0 || m_rr);
        check("req0_ready", req0_ready, p0);
        check("req1_ready", req1_ready, p1);
        last_acc0 = p0;
        last_acc1 = p1;
        @(negedge clock);
        busy_e    = p_busy;
        exp_begin = !m_inflight && (exp_q.size() != 0) && !busy_e;
        exp_done  = 0;
        if (m_inflight) begin
            m_age++;
            if (m_age >= 2) begin
                if (!m_acked) begin
                    if (busy_e) m_acked = 1;
`ifdef IO_SEQ_WATCHDOG_EN
                    else if (m_age == ACK_TIMEOUT + 1) begin
                        m_inflight = 0;
                        m_err      = 1;
                    end
`endif
                end else if (!busy_e) begin
                    exp_done   = 1;
                    m_inflight = 0;
                end
            end
        end
        if (exp_begin) begin
            m_last_data = exp_q.pop_front();
            m_inflight  = 1;
            m_age       = 0;
            m_acked     = 0;
        end
        if (p0) exp_q.push_back(d0);
        if (p1) exp_q.push_back(d1);
        if (v0 && v1 && !full) begin
            m_rr = !m_rr;
            grant_log.push_back(p0 ? 0 : 1);
        end
        check("fifo_count", fifo_count, exp_q.size());
        check("periph_begin", periph_begin, exp_begin);
        check("periph_data", periph_data, m_last_data);
        check("done_pulse", done_pulse, exp_done);
        check("seq_busy", seq_busy, (exp_q.size() != 0) || m_inflight);
        check("err", err, m_err);
        if (periph_begin) begin
            begin_count++;
            issue_log.push_back(periph_data);
        end
        if (done_pulse) done_count++;
        periph_update();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, '0, 0, '0);
    endtask

    task automatic apply_reset();
        req0_valid = 0;
        req1_valid = 0;
        reset_n    = 0;
        #1;
        check("rst_fifo_count", fifo_count, 0);
        check("rst_periph_begin", periph_begin, 0);
        check("rst_periph_data", periph_data, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_done_pulse", done_pulse, 0);
        check("rst_err", err, 0);
        exp_q.delete();
        issue_log.delete();
        grant_log.delete();
        m_rr = 0; m_inflight = 0; m_acked = 0; m_age = 0; m_err = 0;
        m_last_data = '0;
        begin_count = 0;
        done_count  = 0;
        repeat (2) begin
            @(negedge clock);
            periph_update();
        end
        reset_n = 1;
    endtask

    initial begin
        logic [DATA_W-1:0] order[5];
        bit got0, got1;
        checks = 0; failures = 0;
        p_stall = 0; p_noack = 0; p_busy = 0; p_len = 4; p_cnt = 0;
        reset_n = 1; req0_valid = 0; req1_valid = 0;
        req0_data = '0; req1_data = '0; periph_state = '0;
        #2;
        apply_reset();

        // single word with a 32-cycle busy peripheral
        p_len = 32;
        cycle(1, 32'hDEADBEEF, 0, '0);
        check("single_count_accept", fifo_count, 1);
        idle(1);
        check("single_begin", periph_begin, 1);
        check("single_data", periph_data, 32'hDEADBEEF);
        check("single_count_issue", fifo_count, 0);
        idle(32);
        check("single_no_early_done", done_count, 0);
        idle(1);
        check("single_done", done_pulse, 1);
        idle(5);
        check("single_begins", begin_count, 1);
        check("single_dones", done_count, 1);

        // contention: both requesters valid every cycle
        apply_reset();
        p_len = 3;
        repeat (6) cycle(1, 32'h11111111, 1, 32'h22222222);
        idle(40);
        order = '{32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111};
        check("contention_grants", grant_log.size(), 5);
        for (int i = 1; i < grant_log.size(); i++)
            check("contention_alternate", grant_log[i] != grant_log[i-1], 1);
        check("contention_issues", issue_log.size(), 5);
        for (int i = 0; i < 5 && i < issue_log.size(); i++)
            check("contention_order", issue_log[i], order[i]);
        check("contention_dones", done_count, 5);

        // full FIFO with the peripheral busy across reset release
        p_stall = 1;
        p_len   = 4;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'hA0000000 + i, 0, '0);
        check("full_count", fifo_count, 4);
        repeat (6) cycle(1, 32'hA0000004, 1, 32'hA0000005);
        check("full_req0_ready", req0_ready, 0);
        check("full_req1_ready", req1_ready, 0);
        check("full_count_held", fifo_count, 4);
        check("stall_no_begin", begin_count, 0);
        p_stall = 0;
        got0 = 0;
        got1 = 0;
        for (int i = 0; i < 80 && !(got0 && got1); i++) begin
            cycle(!got0, 32'hA0000004, !got1, 32'hA0000005);
            got0 |= last_acc0;
            got1 |= last_acc1;
        end
        check("full_late_accepts", got0 && got1, 1);
        idle(60);
        check("full_issues", issue_log.size(), 6);
        for (int i = 0; i < 6 && i < issue_log.size(); i++)
            check("full_drain_order", issue_log[i], 32'hA0000000 + i);

        // reset during WAIT_DONE with three words queued
        p_len = 20;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'hB0000000 + i, 0, '0);
        idle(3);
        check("mid_queued", fifo_count, 3);
        check("mid_busy_before", seq_busy, 1);
        apply_reset();
        check("mid_periph_still_busy", p_busy, 1);
        cycle(1, 32'h5A5A5A5A, 0, '0);
        idle(40);
        check("mid_issues", issue_log.size(), 1);
        if (issue_log.size() > 0) check("mid_next_word", issue_log[0], 32'h5A5A5A5A);

`ifdef IO_SEQ_WATCHDOG_EN
        // peripheral never acknowledges
        apply_reset();
        p_noack = 1;
        p_len   = 3;
        cycle(1, 32'hC0FFEE00, 0, '0);
        idle(ACK_TIMEOUT + 4);
        check("wd_err", err, 1);
        check("wd_no_done", done_count, 0);
        p_noack = 0;
        cycle(1, 32'hC0FFEE01, 0, '0);
        idle(12);
        check("wd_next_issues", issue_log.size(), 2);
        check("wd_next_done", done_count, 1);
        check("wd_err_sticky", err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
